// File: rtl/mbist_march_sequencer.sv
// mbist_march_sequencer: March C- engine driving a single-port SRAM and checking read data.
module mbist_march_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [2:0] elem;
  logic [ADDR_W-1:0] addr, pend_addr;
  logic op, pend_v, pend_exp, run, two, down, last_op, last_addr, go;
  // Odd elements (M1, M3) write 1s and read 0s; even ones the opposite.
  always_comb begin
    run = state == RUN;
    two = elem inside {3'd1, 3'd2, 3'd3, 3'd4};
    down = elem inside {3'd3, 3'd4};
    last_op = !two || op;
    last_addr = down ? addr == '0 : addr == '1;
    go = start && (state == IDLE || state == DONE);
    mem_re = run && elem != 3'd0 && !op;
    mem_we = run && !mem_re;
    mem_addr = run ? addr : '0;
    mem_wdata = mem_we ? {DATA_W{elem[0]}} : '0;
    busy = run || state == DRAIN;
    done = state == DONE;
    state_nxt = go ? RUN : state == DRAIN ? DONE :
                (run && last_op && last_addr && elem == 3'd5) ? DRAIN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      elem <= '0;
      addr <= '0;
      op <= 1'b0;
      pend_v <= 1'b0;
      pend_exp <= 1'b0;
      pend_addr <= '0;
      fail <= 1'b0;
      fail_addr <= '0;
    end else begin
      state <= state_nxt;
      pend_v <= mem_re;
      pend_exp <= ~elem[0];
      pend_addr <= addr;
      if (go) begin
        elem <= '0;
        addr <= '0;
        op <= 1'b0;
        fail <= 1'b0;
        fail_addr <= '0;
      end else begin
        if (run) begin
          if (!last_op) op <= 1'b1;
          else begin
            op <= 1'b0;
            if (!last_addr) addr <= down ? addr - 1'b1 : addr + 1'b1;
            else if (elem != 3'd5) begin
              elem <= elem + 3'd1;
              addr <= elem inside {3'd2, 3'd3} ? '1 : '0;
            end
          end
        end
        // fail_addr latches only the first mismatch of a run
        if (pend_v && mem_rdata != {DATA_W{pend_exp}}) begin
          fail <= 1'b1;
          if (!fail) fail_addr <= pend_addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_mbist_march_sequencer.sv
// tb_mbist_march_sequencer: table-driven March C- runs against a faultable SRAM model with an op scoreboard.
module tb_mbist_march_sequencer;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic mem_we, mem_re, busy, done, fail;
  int errors = 0, checks = 0;
  int sa1_addr = -1, sa0_a = -1, sa0_b = -1;
  logic [7:0] mem [16];
  logic [13:0] expq [$];

  mbist_march_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      if (int'(mem_addr) == sa1_addr) mem_rdata[0] <= 1'b1;
      if (int'(mem_addr) == sa0_a || int'(mem_addr) == sa0_b) mem_rdata[0] <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input bit we, input bit val, input int a);
    expq.push_back({we, ~we, 4'(a), we ? {8{val}} : 8'h00});
  endtask

  task automatic build_march();
    expq.delete();
    for (int a = 0; a < 16; a++) push(1, 0, a);
    for (int a = 0; a < 16; a++) begin push(0, 0, a); push(1, 1, a); end
    for (int a = 0; a < 16; a++) begin push(0, 0, a); push(1, 0, a); end
    for (int a = 15; a >= 0; a--) begin push(0, 0, a); push(1, 1, a); end
    for (int a = 15; a >= 0; a--) begin push(0, 0, a); push(1, 0, a); end
    for (int a = 0; a < 16; a++) push(0, 0, a);
  endtask

  typedef struct {
    string name;
    int sa1, sa0a, sa0b, restart_at;
    bit exp_fail;
    int exp_faddr;
  } tc_t;

  tc_t tcs [4];

  task automatic run_case(input tc_t tc);
    int c, nwe, nre;
    logic [13:0] e;
    sa1_addr = tc.sa1; sa0_a = tc.sa0a; sa0_b = tc.sa0b;
    build_march();
    c = 0; nwe = 0; nre = 0;
    @(negedge clk);
    start = 1;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (c <= 160) begin
        e = expq.size() > 0 ? expq.pop_front() : 14'h0;
        check({tc.name, " op"}, {mem_we, mem_re, mem_addr, mem_wdata}, e);
      end
      nwe += int'(mem_we);
      nre += int'(mem_re);
      if (c == 1) check({tc.name, " c1 busy/done/fail"}, {busy, done, fail}, 3'b100);
      if (c == 161) check({tc.name, " drain busy/we/re"}, {busy, mem_we, mem_re}, 3'b100);
      if (tc.sa1 == 5 && c == 27) check({tc.name, " fail before compare"}, fail, 0);
      if (tc.sa1 == 5 && c == 29) check({tc.name, " fail after compare"}, {fail, fail_addr}, {1'b1, 4'd5});
      start = (c == tc.restart_at);
      if (done) break;
    end
    start = 0;
    check({tc.name, " done cycle"}, c, 162);
    check({tc.name, " writes"}, nwe, 80);
    check({tc.name, " reads"}, nre, 80);
    check({tc.name, " fail/addr"}, {fail, fail_addr}, {tc.exp_fail, 4'(tc.exp_faddr)});
    repeat (5) @(negedge clk);
    check({tc.name, " done hold"}, {done, busy, mem_we, mem_re, fail, fail_addr}, {4'b1000, tc.exp_fail, 4'(tc.exp_faddr)});
  endtask

  initial begin
    tcs[0] = '{"clean", -1, -1, -1, 0, 1'b0, 0};
    tcs[1] = '{"sa1_w5", 5, -1, -1, 0, 1'b1, 5};
    tcs[2] = '{"sa0_w3_w9", -1, 3, 9, 0, 1'b1, 3};
    tcs[3] = '{"restart_ignored", -1, -1, -1, 40, 1'b0, 0};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("reset outputs", {mem_addr, mem_wdata, mem_we, mem_re, busy, done, fail, fail_addr}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    check("idle holds", {busy, done, mem_we, mem_re}, 0);
    for (int i = 0; i < 4; i++) run_case(tcs[i]);
    sa1_addr = -1; sa0_a = -1; sa0_b = -1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (69) @(negedge clk);
    check("mid-run busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid-run reset", {mem_addr, mem_wdata, mem_we, mem_re, busy, done, fail, fail_addr}, 0);
    repeat (3) @(negedge clk);
    check("after reset idle", {busy, done, mem_we, mem_re}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
